// File: rtl/apb_bfm_pkg.sv
// Shared types and constants for the APB slave memory model.
// Kept separate so the bridge BFM and the slave agree on widths and encodings.
package apb_bfm_pkg;

   localparam int APB_DW     = 32;
   localparam int XFER_CNT_W = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   // The status word occupies the last word of the decoded offset window.
   function automatic logic [APB_DW-1:0] status_offset(input int unsigned addr_width);
      return APB_DW'((64'd1 << addr_width) - 64'd4);
   endfunction

endpackage

// File: rtl/apb_slave_mem_ram.sv
// Single-port word RAM with a registered read port.
// The read is launched at the APB setup phase; writes commit at transfer completion.
module apb_slave_mem_ram
   import apb_bfm_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [IDX_W-1:0]  idx,
   input  logic [APB_DW-1:0] wdata,
   output logic [APB_DW-1:0] rdata
);

   logic [APB_DW-1:0] mem_q [DEPTH];
   logic [APB_DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[idx] <= wdata;
      if (re) rdata_q <= mem_q[idx];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 slave memory model with programmable wait states, error injection,
// a read-only status word and sticky protocol-violation detection.
//
// state  | meaning
// IDLE   | no transfer in flight; setup phase accepted here
// ACCESS | access phase, counting down wait states until PREADY
module apb_slave_mem
   import apb_bfm_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH      = 256,
   parameter int TPD        = 1
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [31:0]           PADDR,
   input  logic [31:0]           PWDATA,
   output logic [31:0]           PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   input  logic [3:0]            WAIT_CYCLES,
   input  logic                  ERR_INJECT,
   output logic [15:0]           XFER_COUNT,
   output logic                  PROT_ERR
);

   localparam int                IDX_W         = $clog2(DEPTH);
   localparam logic [APB_DW-1:0] STATUS_OFFSET = status_offset(ADDR_WIDTH);
   localparam logic [APB_DW-1:0] RAM_BYTES     = APB_DW'(4 * DEPTH);

   if (TPD < 0) begin : g_bad_tpd
      $error("apb_slave_mem: TPD must be non-negative");
   end
   if (4 * DEPTH > (1 << ADDR_WIDTH) - 4) begin : g_bad_depth
      $error("apb_slave_mem: RAM overlaps the status word");
   end

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    err_q, err_d;
   logic                    is_status_q, is_status_d;
   logic                    prot_err_q, prot_err_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [APB_DW-1:0]       status_q, status_d;
   logic [XFER_CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;

   logic [APB_DW-1:0]       offset;
   logic                    sel_status;
   logic                    out_of_range;
   logic                    access_rdy;
   logic                    ram_we;
   logic                    ram_re;
   logic [IDX_W-1:0]        ram_idx;
   logic [APB_DW-1:0]       ram_rdata;
   logic                    unused_paddr;

   assign offset       = APB_DW'({PADDR[ADDR_WIDTH-1:2], 2'b00});
   assign sel_status   = (offset == STATUS_OFFSET);
   assign out_of_range = (offset >= RAM_BYTES) && !sel_status;
   assign access_rdy   = (state_q == ACCESS) && (cnt_q == 4'd0);
   assign unused_paddr = ^{PADDR[31:ADDR_WIDTH], PADDR[1:0]};

   // Setup reads with the live address; completion writes use the latched one.
   assign ram_idx = (state_q == ACCESS) ? idx_q : PADDR[IDX_W+1:2];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      is_status_d = is_status_q;
      idx_d       = idx_q;
      status_d    = status_q;
      prot_err_d  = prot_err_q;
      xfer_cnt_d  = xfer_cnt_q;
      ram_we      = 1'b0;
      ram_re      = 1'b0;
      PREADY      = 1'b0;
      PSLVERR     = 1'b0;
      PRDATA      = '0;

      case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               state_d     = ACCESS;
               cnt_d       = WAIT_CYCLES;
               err_d       = ERR_INJECT | out_of_range;
               is_status_d = sel_status;
               idx_d       = PADDR[IDX_W+1:2];
               status_d    = {{(APB_DW-XFER_CNT_W-1){1'b0}}, prot_err_q, xfer_cnt_q};
               ram_re      = !sel_status && !out_of_range;
            end else if (PSEL && PENABLE) begin
               // Access phase without a setup: complete at once with an error.
               PREADY     = 1'b1;
               PSLVERR    = 1'b1;
               prot_err_d = 1'b1;
               xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(1);
            end
         end
         ACCESS: begin
            PREADY  = access_rdy;
            PSLVERR = access_rdy && err_q;
            if (access_rdy && !PWRITE && !err_q) begin
               PRDATA = is_status_q ? status_q : ram_rdata;
            end
            if (!PSEL) begin
               prot_err_d = 1'b1;
               state_d    = IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (PENABLE) begin
               ram_we     = PWRITE && !err_q && !is_status_q;
               xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(1);
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (PRESET) ram_we = 1'b0;
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         err_q       <= 1'b0;
         is_status_q <= 1'b0;
         idx_q       <= '0;
         status_q    <= '0;
         prot_err_q  <= 1'b0;
         xfer_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         is_status_q <= is_status_d;
         idx_q       <= idx_d;
         status_q    <= status_d;
         prot_err_q  <= prot_err_d;
         xfer_cnt_q  <= xfer_cnt_d;
      end
   end

   apb_slave_mem_ram #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk   (PCLK),
      .we    (ram_we),
      .re    (ram_re),
      .idx   (ram_idx),
      .wdata (PWDATA),
      .rdata (ram_rdata)
   );

   assign XFER_COUNT = xfer_cnt_q;
   assign PROT_ERR   = prot_err_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: table of APB transfers scored through
// an expectation queue, plus hand sequences for protocol, reset and wrap cases.
module tb_apb_slave_mem;

   logic        PCLK = 1'b0;
   logic        PRESET, PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PREADY, PSLVERR;
   logic [3:0]  WAIT_CYCLES;
   logic        ERR_INJECT;
   logic [15:0] XFER_COUNT;
   logic        PROT_ERR;

   always #5 PCLK = ~PCLK;

   apb_slave_mem #(.ADDR_WIDTH(12), .DEPTH(256), .TPD(1)) dut (
      .PCLK        (PCLK),
      .PRESET      (PRESET),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PRDATA      (PRDATA),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR),
      .WAIT_CYCLES (WAIT_CYCLES),
      .ERR_INJECT  (ERR_INJECT),
      .XFER_COUNT  (XFER_COUNT),
      .PROT_ERR    (PROT_ERR)
   );

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          cycles;
   } exp_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  waits;
      logic        inj;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   exp_t        sb_q[$];
   vec_t        vecs[18];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] cnt_model = 16'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic err, input logic [31:0] rdata, input logic [3:0] waits);
      exp_t e;
      e.err    = err;
      e.rdata  = rdata;
      e.cycles = int'(waits) + 1;
      sb_q.push_back(e);
   endtask

   // Called just after a falling edge. Mid-transfer config changes must be ignored.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] waits, input logic inj);
      int   cycles;
      bit   done;
      exp_t e;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
      WAIT_CYCLES = waits; ERR_INJECT = inj;
      @(negedge PCLK);
      PENABLE = 1'b1; WAIT_CYCLES = ~waits; ERR_INJECT = ~inj;
      cycles = 0;
      done   = 1'b0;
      while (!done && cycles < 40) begin
         #1;
         cycles++;
         if (PREADY) begin
            done = 1'b1;
            chk("sb_depth", sb_q.size(), 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               chk("pslverr", PSLVERR, e.err);
               chk("prdata", PRDATA, e.rdata);
               chk("access_cycles", cycles, e.cycles);
            end
         end
         @(negedge PCLK);
      end
      chk("completed", done, 1);
      PSEL = 1'b0; PENABLE = 1'b0; ERR_INJECT = 1'b0; WAIT_CYCLES = 4'd0;
      if (done) cnt_model++;
      chk("xfer_count", XFER_COUNT, cnt_model);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; WAIT_CYCLES = 4'd0; ERR_INJECT = 1'b0;
      repeat (2) @(negedge PCLK);
      chk("rst_pready", PREADY, 0);
      chk("rst_pslverr", PSLVERR, 0);
      chk("rst_prdata", PRDATA, 0);
      chk("rst_count", XFER_COUNT, 0);
      chk("rst_prot_err", PROT_ERR, 0);
      PRESET = 1'b0;
      @(negedge PCLK);

      //          wr    addr          wdata          waits inj  err   rdata
      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'd0, 1'b0, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'd0, 1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'd3, 1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'd0, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 32'h0000_0400, 32'h0000_0055, 4'd0, 1'b0, 1'b1, 32'h0};
      vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         4'd0, 1'b0, 1'b0, 32'hA5A5_A5A5};
      vecs[6]  = '{1'b1, 32'h0000_0020, 32'h0000_1111, 4'd1, 1'b0, 1'b0, 32'h0};
      vecs[7]  = '{1'b1, 32'h0000_0020, 32'h0000_1234, 4'd0, 1'b1, 1'b1, 32'h0};
      vecs[8]  = '{1'b0, 32'h0000_0020, 32'h0,         4'd2, 1'b0, 1'b0, 32'h0000_1111};
      vecs[9]  = '{1'b0, 32'h0000_0800, 32'h0,         4'd0, 1'b0, 1'b1, 32'h0};
      vecs[10] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'd0, 1'b0, 1'b0, 32'h0};
      vecs[11] = '{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 4'd0, 1'b0, 1'b0, 32'h0};
      vecs[12] = '{1'b0, 32'h0000_03FC, 32'h0,         4'd1, 1'b0, 1'b0, 32'h0BAD_F00D};
      vecs[13] = '{1'b1, 32'h0000_0030, 32'hCAFE_0030, 4'd0, 1'b0, 1'b0, 32'h0};
      vecs[14] = '{1'b0, 32'h0000_0020, 32'h0,         4'd0, 1'b1, 1'b1, 32'h0};
      vecs[15] = '{1'b1, 32'h0000_1010, 32'h7777_7777, 4'd0, 1'b0, 1'b0, 32'h0};
      vecs[16] = '{1'b0, 32'h0000_0010, 32'h0,         4'd0, 1'b0, 1'b0, 32'h7777_7777};
      vecs[17] = '{1'b0, 32'h0000_0000, 32'h0,         4'd5, 1'b0, 1'b0, 32'hA5A5_A5A5};

      for (int i = 0; i < 18; i++) begin
         push_exp(vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].waits);
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].inj);
      end

      // Status word before any violation, then a write to it is harmless.
      push_exp(1'b0, {16'h0, cnt_model}, 4'd0);
      xfer(1'b0, 32'h0000_0FFC, 32'h0, 4'd0, 1'b0);

      // Access phase with no setup.
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'hBAD0_BAD0;
      #1;
      chk("prot_pready", PREADY, 1);
      chk("prot_pslverr", PSLVERR, 1);
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
      cnt_model++;
      chk("prot_err_flag", PROT_ERR, 1);
      chk("prot_count", XFER_COUNT, cnt_model);
      push_exp(1'b0, 32'h7777_7777, 4'd0);
      xfer(1'b0, 32'h0000_0010, 32'h0, 4'd0, 1'b0);
      push_exp(1'b0, {15'h0, 1'b1, cnt_model}, 4'd0);
      xfer(1'b0, 32'h0000_0FFC, 32'h0, 4'd0, 1'b0);

      // PSEL dropped mid-wait: abandon, no write, no count.
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h0; WAIT_CYCLES = 4'd3;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
      #1;
      chk("abandon_pready", PREADY, 0);
      @(negedge PCLK);
      chk("abandon_count", XFER_COUNT, cnt_model);
      push_exp(1'b0, 32'h7777_7777, 4'd0);
      xfer(1'b0, 32'h0000_0010, 32'h0, 4'd0, 1'b0);

      // Reset mid-wait of a write to 0x030.
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'hDEAD_DEAD; WAIT_CYCLES = 4'd5;
      @(negedge PCLK);
      PENABLE = 1'b1;
      repeat (2) @(negedge PCLK);
      PRESET = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
      #1;
      cnt_model = 16'd0;
      chk("midrst_pready", PREADY, 0);
      chk("midrst_pslverr", PSLVERR, 0);
      chk("midrst_prdata", PRDATA, 0);
      chk("midrst_count", XFER_COUNT, 0);
      chk("midrst_prot_err", PROT_ERR, 0);
      PRESET = 1'b0;
      @(negedge PCLK);
      push_exp(1'b0, 32'hCAFE_0030, 4'd0);
      xfer(1'b0, 32'h0000_0030, 32'h0, 4'd0, 1'b0);

      // Reset on what would have been the completion edge: no commit.
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'h0BAD_0030; WAIT_CYCLES = 4'd0;
      @(negedge PCLK);
      PENABLE = 1'b1; PRESET = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
      cnt_model = 16'd0;
      chk("cplrst_count", XFER_COUNT, cnt_model);
      @(negedge PCLK);
      push_exp(1'b0, 32'hCAFE_0030, 4'd0);
      xfer(1'b0, 32'h0000_0030, 32'h0, 4'd0, 1'b0);

      // Wrap: one-cycle violation transfers, count starts at 1 here.
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h0;
      repeat (65534) @(posedge PCLK);
      @(negedge PCLK);
      chk("wrap_ffff", XFER_COUNT, 32'h0000_FFFF);
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
      chk("wrap_zero", XFER_COUNT, 0);
      chk("wrap_prot_err", PROT_ERR, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
